// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback path: register index and
// data widths, the hard-wired zero register and the writeback requester slots.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  // Writes to this register index are architecturally discarded.
  localparam int unsigned REG_ZERO = 0;

  // Writeback requester slots, lowest index first in the round-robin order.
  localparam int WB_ALU    = 0;
  localparam int WB_LOAD   = 1;
  localparam int WB_MULDIV = 2;

  // Round-robin successor of idx among n requesters, wrapping n-1 -> 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters (master side) and the register-file
// write port arbiter (slave side). Request fields are packed per requester.
interface regfile_wb_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    hold;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [IDX_W-1:0]        last_grant;

  // Requesters and the write-port owner drive requests and hold.
  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready, wr_en, wr_addr, wr_data, last_grant
  );

  // The arbiter grants and drives the register-file write port.
  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready, wr_en, wr_addr, wr_data, last_grant
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: scans req starting at the pointer,
// wrapping modulo N_REQ, and returns a one-hot grant plus its encoded index.
// Reusable wherever a single port is shared among N requesters.
module regfile_wb_arbiter_rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // First requester at or after the pointer wins; nothing wins when disabled.
  always_comb begin
    int j;
    // NOTE: every output gets a default before the loop so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (i_en && !o_valid && i_req[j]) begin
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port arbiter: grants one writeback source per cycle in
// round-robin order and registers the winning write strobe, index and data.
// Writes to the zero register are accepted but never strobed into the file.
// N_REQ is meant to stay within 2..8.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]  r_ptr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [IDX_W-1:0]  r_last_grant;

  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_idx;
  logic              w_xfer;
  logic              w_arb_en;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [IDX_W-1:0]  w_next_ptr;

  assign w_arb_en = ~bus.hold;

  regfile_wb_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req   (bus.req_valid),
    .i_en    (w_arb_en),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_xfer)
  );

  // A grant is only issued to a valid requester, so any grant is a transfer.
  assign bus.req_ready = w_grant;
  assign w_sel_addr    = bus.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_sel_data    = bus.req_data[int'(w_idx)*DATA_W +: DATA_W];
  assign w_next_ptr    = IDX_W'(rr_next(int'(w_idx), N_REQ));

  // Output register and pointer: capture the winner, drop the strobe for $0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_last_grant <= '0;
      r_ptr        <= '0;
    end else begin
      r_wr_en <= w_xfer && (w_sel_addr != ADDR_W'(REG_ZERO));
      if (w_xfer) begin
        r_wr_addr    <= w_sel_addr;
        r_wr_data    <= w_sel_data;
        r_last_grant <= w_idx;
        r_ptr        <= w_next_ptr;
      end
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.last_grant = r_last_grant;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a driver applies directed per-cycle vectors,
// checks the combinational grant in-cycle and queues the hand-computed
// registered outputs; a monitor pops and compares them after each edge.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    int          cyc;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  lg;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_err;
  exp_t sb_q[$];

  regfile_wb_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  // Drive one cycle, check the grant, queue the outputs expected after the edge.
  task automatic step(input string name, input logic rst_v, input logic hold_v,
                      input logic [2:0] val, input logic chk_rdy, input logic [2:0] exp_rdy,
                      input logic exp_en, input logic [4:0] exp_addr,
                      input logic [31:0] exp_data, input logic [1:0] exp_lg);
    exp_t e;
    rst           = rst_v;
    bus.hold      = hold_v;
    bus.req_valid = val;
    #1;
    if (chk_rdy) check({name, " ready"}, 64'(bus.req_ready), 64'(exp_rdy));
    e.cyc  = cyc + 1;
    e.en   = exp_en;
    e.addr = exp_addr;
    e.data = exp_data;
    e.lg   = exp_lg;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: after each edge, compare the registered outputs due this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      if (sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        check($sformatf("stale entry c%0d", e.cyc), 64'(cyc), 64'(e.cyc));
      end else if (sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        check($sformatf("wr_en c%0d", e.cyc),      64'(bus.wr_en),      64'(e.en));
        check($sformatf("wr_addr c%0d", e.cyc),    64'(bus.wr_addr),    64'(e.addr));
        check($sformatf("wr_data c%0d", e.cyc),    64'(bus.wr_data),    64'(e.data));
        check($sformatf("last_grant c%0d", e.cyc), 64'(bus.last_grant), 64'(e.lg));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b0;
    bus.hold = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    set_req(0, 5'd1, 32'h0000BABE);
    set_req(1, 5'd2, 32'h0000BABF);
    set_req(2, 5'd3, 32'h0000BAC0);

    // Reset for two edges with everything valid.
    step("rst1", 1'b0, 1'b0, 3'b111, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 2'd0);
    step("rst2", 1'b0, 1'b0, 3'b111, 1'b1, 3'b001, 1'b0, 5'd0, 32'h0, 2'd0);

    // Round-robin from requester 0, six back-to-back grants.
    step("rr0", 1'b1, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 5'd1, 32'h0000BABE, 2'd0);
    step("rr1", 1'b1, 1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 5'd2, 32'h0000BABF, 2'd1);
    step("rr2", 1'b1, 1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 5'd3, 32'h0000BAC0, 2'd2);
    step("rr3", 1'b1, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 5'd1, 32'h0000BABE, 2'd0);
    step("rr4", 1'b1, 1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 5'd2, 32'h0000BABF, 2'd1);
    step("rr5", 1'b1, 1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 5'd3, 32'h0000BAC0, 2'd2);
    step("idle0", 1'b1, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 5'd3, 32'h0000BAC0, 2'd2);

    // Single source: requester 1 writes DEADBEEF to r8, then outputs hold.
    set_req(1, 5'd8, 32'hDEADBEEF);
    step("single", 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 1'b1, 5'd8, 32'hDEADBEEF, 2'd1);
    step("idle1",  1'b1, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 5'd8, 32'hDEADBEEF, 2'd1);

    // $0 discard from requester 2; pointer must wrap to 0 even with 2 valid.
    set_req(2, 5'd0, 32'h1111BABE);
    step("zero", 1'b1, 1'b0, 3'b100, 1'b1, 3'b100, 1'b0, 5'd0, 32'h1111BABE, 2'd2);
    set_req(0, 5'd5, 32'h00000005);
    step("wrap", 1'b1, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 5'd5, 32'h00000005, 2'd0);

    // Hold for three cycles, then resume at the frozen pointer (1).
    step("hold0", 1'b1, 1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 5'd5, 32'h00000005, 2'd0);
    step("hold1", 1'b1, 1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 5'd5, 32'h00000005, 2'd0);
    step("hold2", 1'b1, 1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 5'd5, 32'h00000005, 2'd0);
    step("resume", 1'b1, 1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 5'd8, 32'hDEADBEEF, 2'd1);

    // Reset on the same edge as a requester-1 transfer; restart at 0.
    step("rst_mid", 1'b0, 1'b0, 3'b010, 1'b1, 3'b010, 1'b0, 5'd0, 32'h0, 2'd0);
    step("post_rst", 1'b1, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 5'd5, 32'h00000005, 2'd0);

    // Same destination from two sources: written in grant order, later wins.
    set_req(1, 5'd9, 32'h0000000A);
    set_req(2, 5'd9, 32'h0000000B);
    step("same_a", 1'b1, 1'b0, 3'b110, 1'b1, 3'b010, 1'b1, 5'd9, 32'h0000000A, 2'd1);
    step("same_b", 1'b1, 1'b0, 3'b100, 1'b1, 3'b100, 1'b1, 5'd9, 32'h0000000B, 2'd2);
    step("idle2",  1'b1, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 5'd9, 32'h0000000B, 2'd2);

    repeat (2) @(negedge clk);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
